// File: rtl/adj_combination_if.sv
// Bus between the adjacency combination stage, its row memories and the argmax reader.
// The slave side is the combination engine; the master side supplies rows and reads results.
interface adj_combination_if #(
    parameter int unsigned NUM_NODES        = 6,
    parameter int unsigned FINAL_MATRIX_COL = 3,
    parameter int unsigned DOT_PROD_WIDTH   = 16,
    parameter int unsigned ROW_WIDTH        = $clog2(NUM_NODES) + 1
);
    logic                      start;
    logic [ROW_WIDTH-1:0]      adj_addr;
    logic [NUM_NODES-1:0]      adj_row_in;
    logic [ROW_WIDTH-1:0]      fmwm_addr;
    logic [DOT_PROD_WIDTH-1:0] fmwm_row_in [0:FINAL_MATRIX_COL-1];
    logic [ROW_WIDTH-1:0]      read_row;
    logic [DOT_PROD_WIDTH-1:0] adj_fm_wm_out [0:FINAL_MATRIX_COL-1];
    logic                      busy;
    logic                      done_comb;

    modport slave (
        input  start, adj_row_in, fmwm_row_in, read_row,
        output adj_addr, fmwm_addr, adj_fm_wm_out, busy, done_comb
    );

    modport master (
        output start, adj_row_in, fmwm_row_in, read_row,
        input  adj_addr, fmwm_addr, adj_fm_wm_out, busy, done_comb
    );
endinterface

// File: rtl/adj_combination.sv
// Computes final = adj x FM_WM for a binary adjacency matrix, one FM_WM row per cycle,
// and serves the finished rows to the downstream argmax stage.
module adj_combination #(
    parameter int unsigned NUM_NODES        = 6,
    parameter int unsigned FINAL_MATRIX_COL = 3,
    parameter int unsigned DOT_PROD_WIDTH   = 16,
    parameter int unsigned ROW_WIDTH        = $clog2(NUM_NODES) + 1
) (
    input logic              clk,
    input logic              reset,
    adj_combination_if.slave bus
);
    localparam int unsigned          IDX_W = (NUM_NODES > 1) ? $clog2(NUM_NODES) : 1;
    localparam logic [ROW_WIDTH-1:0] LAST  = ROW_WIDTH'(NUM_NODES - 1);
    localparam logic [ROW_WIDTH-1:0] NODES = ROW_WIDTH'(NUM_NODES);

    typedef enum logic [1:0] {StIdle, StAccum, StWrite, StDone} state_e;

    state_e                    state_q, state_d;
    logic [ROW_WIDTH-1:0]      i_q, k_q;
    logic [DOT_PROD_WIDTH-1:0] acc_q [FINAL_MATRIX_COL];
    logic [DOT_PROD_WIDTH-1:0] mem_q [NUM_NODES][FINAL_MATRIX_COL];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state_q <= StIdle;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle, StDone: if (bus.start) state_d = StAccum;
            StAccum:        if (k_q == LAST) state_d = StWrite;
            StWrite:        state_d = (i_q == LAST) ? StDone : StAccum;
            default:        state_d = StIdle;
        endcase
    end

    always_comb begin
        bus.busy      = 1'b0;
        bus.done_comb = 1'b0;
        bus.adj_addr  = '0;
        bus.fmwm_addr = '0;
        unique case (state_q)
            StAccum: begin
                bus.busy      = 1'b1;
                bus.adj_addr  = i_q;
                bus.fmwm_addr = k_q;
            end
            StWrite: bus.busy      = 1'b1;
            StDone:  bus.done_comb = 1'b1;
            default: ;
        endcase
    end

    // Sums wrap naturally at DOT_PROD_WIDTH bits.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            i_q <= '0;
            k_q <= '0;
            for (int j = 0; j < FINAL_MATRIX_COL; j++) acc_q[j] <= '0;
            for (int r = 0; r < NUM_NODES; r++) begin
                for (int j = 0; j < FINAL_MATRIX_COL; j++) mem_q[r][j] <= '0;
            end
        end else begin
            unique case (state_q)
                StIdle, StDone: begin
                    if (bus.start) begin
                        i_q <= '0;
                        k_q <= '0;
                        for (int j = 0; j < FINAL_MATRIX_COL; j++) acc_q[j] <= '0;
                    end
                end
                StAccum: begin
                    if (bus.adj_row_in[k_q[IDX_W-1:0]]) begin
                        for (int j = 0; j < FINAL_MATRIX_COL; j++) begin
                            acc_q[j] <= acc_q[j] + bus.fmwm_row_in[j];
                        end
                    end
                    k_q <= k_q + ROW_WIDTH'(1);
                end
                StWrite: begin
                    for (int j = 0; j < FINAL_MATRIX_COL; j++) begin
                        mem_q[i_q[IDX_W-1:0]][j] <= acc_q[j];
                        acc_q[j]                 <= '0;
                    end
                    k_q <= '0;
                    if (i_q != LAST) i_q <= i_q + ROW_WIDTH'(1);
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        for (int j = 0; j < FINAL_MATRIX_COL; j++) bus.adj_fm_wm_out[j] = '0;
        if (bus.read_row < NODES) begin
            for (int j = 0; j < FINAL_MATRIX_COL; j++) begin
                bus.adj_fm_wm_out[j] = mem_q[bus.read_row[IDX_W-1:0]][j];
            end
        end
    end
endmodule

// File: tb/tb_adj_combination.sv
// Randomized scoreboard bench for adj_combination against a matrix-product reference model.
module tb_adj_combination;
    localparam int N         = 6;
    localparam int C         = 3;
    localparam int W         = 16;
    localparam int RW        = $clog2(N) + 1;
    localparam int IW        = $clog2(N);
    localparam int DONE_EDGE = N * (N + 1);

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    adj_combination_if #(.NUM_NODES(N), .FINAL_MATRIX_COL(C), .DOT_PROD_WIDTH(W),
                         .ROW_WIDTH(RW)) bus ();

    adj_combination #(.NUM_NODES(N), .FINAL_MATRIX_COL(C), .DOT_PROD_WIDTH(W),
                      .ROW_WIDTH(RW)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    logic [N-1:0] adj_mem   [N];
    logic [W-1:0] fm_mem    [N][C];
    logic [W-1:0] cur_final [N][C];
    logic [W-1:0] new_final [N][C];

    // Combinational row memories answering the DUT's address requests.
    always_comb begin
        bus.adj_row_in = adj_mem[bus.adj_addr[IW-1:0]];
        for (int j = 0; j < C; j++) bus.fmwm_row_in[j] = fm_mem[bus.fmwm_addr[IW-1:0]][j];
    end

    typedef struct {
        int          kind;  // 0: output row, 1: {busy,done_comb}, 2: {adj_addr,fmwm_addr}
        string       name;
        logic [47:0] want;
    } exp_t;

    exp_t exp_q[$];
    int   total = 0;
    int   bad   = 0;

    task automatic expect_item(input int kind, input string name, input logic [47:0] want);
        exp_t e;
        e.kind = kind;
        e.name = name;
        e.want = want;
        exp_q.push_back(e);
    endtask

    task automatic check_now(input string name, input logic [47:0] got,
                             input logic [47:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s: got %h want %h (t=%0t)", name, got, want, $time);
        end
    endtask

    initial begin
        forever begin
            @(negedge clk);
            while (exp_q.size() > 0) begin
                exp_t        e;
                logic [47:0] got;
                e = exp_q.pop_front();
                case (e.kind)
                    0:       got = {bus.adj_fm_wm_out[0], bus.adj_fm_wm_out[1],
                                    bus.adj_fm_wm_out[2]};
                    1:       got = {46'd0, bus.busy, bus.done_comb};
                    default: got = {40'd0, bus.adj_addr, bus.fmwm_addr};
                endcase
                total++;
                if (got !== e.want) begin
                    bad++;
                    $display("FAIL %s: got %h want %h (t=%0t)", e.name, got, e.want, $time);
                end
            end
        end
    end

    function automatic void compute_model();
        for (int i = 0; i < N; i++) begin
            for (int j = 0; j < C; j++) begin
                int s;
                s = 0;
                for (int k = 0; k < N; k++) if (adj_mem[i][k]) s += int'(fm_mem[k][j]);
                new_final[i][j] = W'(s);
            end
        end
    endfunction

    function automatic logic [47:0] cur_row(input int r);
        if (r >= N) return '0;
        return {cur_final[r][0], cur_final[r][1], cur_final[r][2]};
    endfunction

    function automatic logic [47:0] new_row(input int r);
        if (r >= N) return '0;
        return {new_final[r][0], new_final[r][1], new_final[r][2]};
    endfunction

    // Row r is requested during edges 7r..7r+5 after start, written on edge 7r+7.
    function automatic logic [47:0] exp_addr(input int n);
        int r, p;
        if (n >= DONE_EDGE) return '0;
        r = n / (N + 1);
        p = n % (N + 1);
        if (p < N) return {40'd0, RW'(r), RW'(p)};
        return '0;
    endfunction

    task automatic check_row(input int r, input logic [47:0] want, input string name);
        bus.read_row = RW'(r);
        expect_item(0, name, want);
        @(posedge clk);
        #1;
    endtask

    task automatic sweep();
        for (int r = 0; r < 8; r++) begin
            bus.read_row = RW'(r);
            expect_item(0, "sweep_row", cur_row(r));
            expect_item(1, "sweep_status", 48'd1);
            @(posedge clk);
            #1;
        end
    endtask

    task automatic run_pass(input int pulse_at, input int reset_at);
        int          r;
        logic [47:0] want;
        compute_model();
        bus.start = 1'b1;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        for (int n = 0; n <= DONE_EDGE + 3; n++) begin
            if (n == reset_at) begin
                reset = 1'b1;
                #1;
                check_now("reset_status_now", {46'd0, bus.busy, bus.done_comb}, 48'd0);
                check_now("reset_addr_now", {40'd0, bus.adj_addr, bus.fmwm_addr}, 48'd0);
                expect_item(1, "reset_status", 48'd0);
                expect_item(2, "reset_addr", 48'd0);
                for (int rr = 0; rr < N; rr++) begin
                    bus.read_row = RW'(rr);
                    expect_item(0, "reset_row", 48'd0);
                    @(negedge clk);
                    #1;
                end
                for (int a = 0; a < N; a++) for (int j = 0; j < C; j++) cur_final[a][j] = '0;
                reset = 1'b0;
                return;
            end
            bus.start    = (n == pulse_at);
            r            = int'($urandom_range(0, 7));
            bus.read_row = RW'(r);
            want = (r < N && n >= (r + 1) * (N + 1)) ? new_row(r) : cur_row(r);
            expect_item(0, "pass_row", want);
            expect_item(1, "pass_status", {46'd0, n < DONE_EDGE, n >= DONE_EDGE});
            expect_item(2, "pass_addr", exp_addr(n));
            @(posedge clk);
            #1;
        end
        check_now("done_after_wait", {46'd0, bus.busy, bus.done_comb}, 48'd1);
        bus.start = 1'b0;
        cur_final = new_final;
    endtask

    task automatic fill_random();
        for (int i = 0; i < N; i++) begin
            adj_mem[i] = N'($urandom);
            for (int j = 0; j < C; j++) fm_mem[i][j] = W'($urandom);
        end
    endtask

    initial begin
        reset        = 1'b1;
        bus.start    = 1'b0;
        bus.read_row = '0;
        for (int i = 0; i < N; i++) begin
            adj_mem[i] = '0;
            for (int j = 0; j < C; j++) begin
                fm_mem[i][j]    = '0;
                cur_final[i][j] = '0;
            end
        end
        #1;
        check_now("rst_status_now", {46'd0, bus.busy, bus.done_comb}, 48'd0);
        expect_item(1, "rst_status", 48'd0);
        expect_item(2, "rst_addr", 48'd0);
        expect_item(0, "rst_row", 48'd0);
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;

        // Identity adjacency, fmwm row k = {k, 2k, 3k}.
        for (int i = 0; i < N; i++) begin
            adj_mem[i] = N'(1) << i;
            for (int j = 0; j < C; j++) fm_mem[i][j] = W'(i * (j + 1));
        end
        run_pass(-1, -1);
        check_row(4, {16'd4, 16'd8, 16'd12}, "ident_row4");
        sweep();

        // All-ones adjacency and all-ones fmwm.
        for (int i = 0; i < N; i++) begin
            adj_mem[i] = '1;
            for (int j = 0; j < C; j++) fm_mem[i][j] = 16'd1;
        end
        run_pass(-1, -1);
        for (int r = 0; r < N; r++) check_row(r, {16'd6, 16'd6, 16'd6}, "ones_row");
        sweep();

        // Wrap-around in row 0.
        fill_random();
        adj_mem[0] = 6'b000011;
        for (int k = 0; k < 2; k++) begin
            fm_mem[k][0] = 16'hFFFF;
            fm_mem[k][1] = 16'd1;
            fm_mem[k][2] = 16'd0;
        end
        run_pass(-1, -1);
        check_row(0, {16'hFFFE, 16'd2, 16'd0}, "wrap_row0");
        check_row(6, 48'd0, "oob_row6");
        check_row(7, 48'd0, "oob_row7");
        sweep();

        // Stray start sampled on edge 10 of a pass.
        fill_random();
        run_pass(9, -1);
        sweep();

        // Reset on edge 20, then a clean pass from IDLE.
        fill_random();
        run_pass(-1, 20);
        fill_random();
        run_pass(-1, -1);
        sweep();

        for (int t = 0; t < 3; t++) begin
            fill_random();
            run_pass(-1, -1);
            sweep();
        end

        @(negedge clk);
        #1;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
